// File: rtl/div_seq_s42u16.sv
// Iterative restoring divider: signed ASIZE-bit dividend / unsigned BSIZE-bit divisor -> saturated signed quotient.
// Optional build macro DIV_ROUND_NEAREST_EN: round half away from zero instead of truncating.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one restoring step per cycle, ASIZE steps
// FIX   | apply sign, rounding, saturation and flags to the result registers
// DONE  | result held with out_valid=1 until consumed
module div_seq_s42u16 #(
  parameter int ASIZE = 42,
  parameter int BSIZE = 16,
  parameter int QSIZE = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ASIZE-1:0] a,
  input  logic [BSIZE-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QSIZE-1:0] q,
  output logic [BSIZE:0]   r,
  output logic             ovf,
  output logic             dz
);

  localparam int CW = $clog2(ASIZE);
  localparam logic [ASIZE:0]   QPOS_LIM = (ASIZE+1)'((64'd1 << (QSIZE-1)) - 64'd1);
  localparam logic [ASIZE:0]   QNEG_LIM = (ASIZE+1)'(64'd1 << (QSIZE-1));
  localparam logic [QSIZE-1:0] Q_MAX    = {1'b0, {(QSIZE-1){1'b1}}};
  localparam logic [QSIZE-1:0] Q_MIN    = {1'b1, {(QSIZE-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [ASIZE-1:0]   acc_q, acc_d;
  logic [BSIZE-1:0]   rem_q, rem_d;
  logic [BSIZE-1:0]   div_q, div_d;
  logic               neg_q, neg_d;
  logic               bz_q, bz_d;
  logic [QSIZE-1:0]   q_q, q_d;
  logic [BSIZE:0]     r_q, r_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;

  logic [ASIZE-1:0]   a_mag;
  logic [BSIZE:0]     partial;
  logic [BSIZE:0]     diff;
  logic               step_ge;
  logic [ASIZE:0]     qmag;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign q   = q_q;
  assign r   = r_q;
  assign ovf = ovf_q;
  assign dz  = dz_q;

  // Most negative dividend maps to 2^(ASIZE-1), which still fits the unsigned magnitude.
  assign a_mag   = a[ASIZE-1] ? (~a + ASIZE'(1)) : a;
  assign partial = {rem_q, acc_q[ASIZE-1]};
  assign step_ge = (partial >= {1'b0, div_q});
  assign diff    = partial - {1'b0, div_q};

`ifdef DIV_ROUND_NEAREST_EN
  logic round_up;
  assign round_up = ({rem_q, 1'b0} >= {1'b0, div_q});
  assign qmag     = {1'b0, acc_q} + {{ASIZE{1'b0}}, round_up};
`else
  assign qmag     = {1'b0, acc_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    div_d   = div_q;
    neg_d   = neg_q;
    bz_d    = bz_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CALC;
          cnt_d   = CW'(ASIZE-1);
          acc_d   = a_mag;
          rem_d   = '0;
          div_d   = b;
          neg_d   = a[ASIZE-1];
          bz_d    = (b == '0);
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
        end
      end
      S_CALC: begin
        // A zero divisor idles the datapath but still walks the counter, so latency is uniform.
        if (!bz_q) begin
          acc_d = {acc_q[ASIZE-2:0], step_ge};
          rem_d = step_ge ? diff[BSIZE-1:0] : partial[BSIZE-1:0];
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        state_d = S_DONE;
        ovf_d   = 1'b0;
        dz_d    = 1'b0;
        if (bz_q) begin
          q_d  = neg_q ? Q_MIN : Q_MAX;
          r_d  = '0;
          dz_d = 1'b1;
        end else begin
          r_d = neg_q ? (~{1'b0, rem_q} + (BSIZE+1)'(1)) : {1'b0, rem_q};
          if (!neg_q) begin
            if (qmag > QPOS_LIM) begin
              q_d   = Q_MAX;
              ovf_d = 1'b1;
            end else begin
              q_d = qmag[QSIZE-1:0];
            end
          end else if (qmag > QNEG_LIM) begin
            q_d   = Q_MIN;
            ovf_d = 1'b1;
          end else begin
            q_d = ~qmag[QSIZE-1:0] + QSIZE'(1);
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      neg_q   <= 1'b0;
      bz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      bz_q    <= bz_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

endmodule
